// File: rtl/ddr3_test_pkg.sv
// Shared types and constants for the DDR3 memory tester.
// DDR3_TEST_LFSR_EN selects the LFSR data pattern; these definitions are
// harmless when it is undefined.
package ddr3_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CAL,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE,
    ST_CAL_ERR
  } state_e;

  // Galois form of x^32+x^22+x^2+x+1, right-shifting
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  // Width needed to hold 0..max_outst
  function automatic int unsigned outst_w(input int unsigned max_outst);
    return $clog2(max_outst + 1);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/ddr3_mem_tester_if.sv
// Avalon-MM master bus between the tester and the memory controller.
interface ddr3_mem_tester_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 64
) ();

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_write;
  logic                avm_read;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/ddr3_pattern_gen.sv
// Test data pattern source. Even 32-bit lanes carry the base word, odd
// lanes its inverse. Base word is the word address by default, or a
// 32-bit Galois LFSR when DDR3_TEST_LFSR_EN is defined.
module ddr3_pattern_gen
  import ddr3_test_pkg::*;
#(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              advance_i,
  input  logic              reseed_i,
  output logic [DATA_W-1:0] pattern_o
);

  logic [31:0] word;

`ifdef DDR3_TEST_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic        unused_addr;

  // Reseed has priority over advance
  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed_i)       lfsr_d = LFSR_SEED;
    else if (advance_i) lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign word        = lfsr_q;
  assign unused_addr = &{1'b0, address_i};
`else
  logic unused_ctl;

  assign word       = 32'(address_i);
  assign unused_ctl = &{1'b0, clk, rst_n, advance_i, reseed_i};
`endif

  // Replicate base word across lanes, inverting odd lanes
  always_comb begin
    pattern_o = '0;
    for (int unsigned i = 0; i < DATA_W / 32; i++) begin
      pattern_o[i*32 +: 32] = i[0] ? ~word : word;
    end
  end

endmodule

// File: rtl/ddr3_mem_tester.sv
// DDR3 memory tester: waits for calibration, writes a pattern over
// 0..END_ADDR, reads it back with up to MAX_OUTST reads in flight and
// counts mismatches. Define DDR3_TEST_LFSR_EN for the LFSR pattern.
module ddr3_mem_tester
  import ddr3_test_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 24,
  parameter int unsigned       DATA_W    = 64,
  parameter logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(24'hFF_FFFF),
  parameter int unsigned       MAX_OUTST = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 init_done,
  input  logic                 cal_success,
  input  logic                 cal_fail,
  ddr3_mem_tester_if.master    avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [15:0]          err_count,
  output logic [ADDR_W-1:0]    first_err_addr
);

  localparam int unsigned     OW        = outst_w(MAX_OUTST);
  localparam logic [OW-1:0]   OUTST_MAX = OW'(MAX_OUTST);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cmp_ptr_q, cmp_ptr_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              pass_q, pass_d, fail_q, fail_d, done_q, done_d;

  logic [DATA_W-1:0] wr_pat, cmp_pat;
  logic              rd_en, wr_acc, rd_iss, rd_ret, mism, run_start, enter_read;

  assign rd_en      = (state_q == ST_READ) && (outst_q < OUTST_MAX);
  assign wr_acc     = (state_q == ST_WRITE) && !avm.avm_waitrequest;
  assign rd_iss     = rd_en && !avm.avm_waitrequest;
  assign rd_ret     = avm.avm_readdatavalid && (state_q inside {ST_READ, ST_DRAIN});
  assign mism       = rd_ret && (avm.avm_readdata != cmp_pat);
  assign run_start  = start && (state_q inside {ST_IDLE, ST_DONE, ST_CAL_ERR});
  assign enter_read = wr_acc && (addr_q == END_ADDR);

  ddr3_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
    .clk       (clk),
    .rst_n     (reset_n),
    .address_i (addr_q),
    .advance_i (wr_acc),
    .reseed_i  (run_start),
    .pattern_o (wr_pat)
  );

  ddr3_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_pat (
    .clk       (clk),
    .rst_n     (reset_n),
    .address_i (cmp_ptr_q),
    .advance_i (rd_ret),
    .reseed_i  (enter_read),
    .pattern_o (cmp_pat)
  );

  // Commands depend only on registered state, so they hold under waitrequest
  assign avm.avm_address    = addr_q;
  assign avm.avm_write      = (state_q == ST_WRITE);
  assign avm.avm_read       = rd_en;
  assign avm.avm_writedata  = (state_q == ST_WRITE) ? wr_pat : '0;
  assign avm.avm_byteenable = '1;

  assign busy           = state_q inside {ST_WAIT_CAL, ST_WRITE, ST_READ, ST_DRAIN};
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  // Next-state and datapath updates for the test sequencer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cmp_ptr_d = cmp_ptr_q;
    outst_d   = outst_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    done_d    = done_q;

    unique case ({rd_iss, rd_ret})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    // err_d is settled here so the DONE verdict below sees the final compare
    if (rd_ret) begin
      cmp_ptr_d = (cmp_ptr_q == END_ADDR) ? '0 : cmp_ptr_q + 1'b1;
      if (mism) begin
        if (err_q == 16'h0000) ferr_d = cmp_ptr_q;
        if (err_q != 16'hFFFF) err_d  = err_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_CAL_ERR: begin
        if (run_start) begin
          state_d   = ST_WAIT_CAL;
          addr_d    = '0;
          cmp_ptr_d = '0;
          err_d     = '0;
          ferr_d    = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          done_d    = 1'b0;
        end
      end
      ST_WAIT_CAL: begin
        if (cal_fail) begin
          state_d = ST_CAL_ERR;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (init_done && cal_success) begin
          state_d = ST_WRITE;
          addr_d  = '0;
        end
      end
      ST_WRITE: begin
        if (wr_acc) begin
          if (addr_q == END_ADDR) begin
            state_d = ST_READ;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_iss) begin
          if (addr_q == END_ADDR) begin
            state_d = ST_DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (rd_ret && (cmp_ptr_q == END_ADDR)) begin
          state_d = ST_DONE;
          pass_d  = (err_d == 16'h0000);
          fail_d  = (err_d != 16'h0000);
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cmp_ptr_q <= '0;
      outst_q   <= '0;
      err_q     <= '0;
      ferr_q    <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cmp_ptr_q <= cmp_ptr_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ddr3_mem_tester.sv
// Bench for ddr3_mem_tester with END_ADDR=15 and an Avalon slave model.
module tb_ddr3_mem_tester;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 64;
  localparam int unsigned MO = 8;
  localparam logic [AW-1:0] END_A = 24'd15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic init_done = 1'b0;
  logic cal_success = 1'b0;
  logic cal_fail = 1'b0;
  logic busy, done, pass, fail;
  logic [15:0] err_count;
  logic [AW-1:0] first_err_addr;

  ddr3_mem_tester_if #(.ADDR_W(AW), .DATA_W(DW)) avm ();

  ddr3_mem_tester #(
    .ADDR_W(AW), .DATA_W(DW), .END_ADDR(END_A), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .init_done(init_done), .cal_success(cal_success), .cal_fail(cal_fail),
    .avm(avm),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {8'h00, a};
    return {~w, w};
  endfunction

  // Slave model configuration
  int          lat = 2;
  bit          ws_alt = 1'b0;
  logic [15:0] corrupt_mask = '0;

  typedef struct { int due; logic [AW-1:0] addr; } rd_t;

  logic [63:0]   mem [0:15];
  rd_t           pipe [$];
  rd_t           ret;
  logic [AW-1:0] exp_wr [$];
  logic [AW-1:0] exp_rd [$];
  logic [AW-1:0] a_pop;
  int cyc = 0, outst = 0, max_outst = 0, wr_cnt = 0, rd_cnt = 0;
  logic          prev_wr_stall = 1'b0, prev_rd_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [63:0]   prev_wdata;

  // Slave + scoreboard: drive responses and judge accepted commands at negedge
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      pipe.delete();
      outst = 0;
      avm.avm_waitrequest = 1'b0;
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata = '0;
      prev_wr_stall = 1'b0;
      prev_rd_stall = 1'b0;
    end else begin
      if (prev_wr_stall) begin
        check_eq("wr_stall_addr", {39'b0, avm.avm_write, avm.avm_address}, {39'b0, 1'b1, prev_addr});
        check_eq("wr_stall_data", avm.avm_writedata, prev_wdata);
      end
      if (prev_rd_stall)
        check_eq("rd_stall_addr", {39'b0, avm.avm_read, avm.avm_address}, {39'b0, 1'b1, prev_addr});

      avm.avm_waitrequest = ws_alt ? (cyc % 2 == 0) : 1'b0;

      if (avm.avm_write && !avm.avm_waitrequest) begin
        wr_cnt++;
        check_eq("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
        if (exp_wr.size() > 0) begin
          a_pop = exp_wr.pop_front();
          check_eq("wr_addr", 64'(avm.avm_address), 64'(a_pop));
          check_eq("wr_data", avm.avm_writedata, pat(a_pop));
        end
        mem[avm.avm_address[3:0]] = avm.avm_writedata;
      end

      if (avm.avm_read && !avm.avm_waitrequest) begin
        rd_cnt++;
        check_eq("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
        if (exp_rd.size() > 0) begin
          a_pop = exp_rd.pop_front();
          check_eq("rd_addr", 64'(avm.avm_address), 64'(a_pop));
        end
        pipe.push_back('{due: cyc + lat, addr: avm.avm_address});
        outst++;
        if (outst > max_outst) max_outst = outst;
      end

      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        ret = pipe.pop_front();
        avm.avm_readdata = mem[ret.addr[3:0]] ^ 64'(corrupt_mask[ret.addr[3:0]]);
        avm.avm_readdatavalid = 1'b1;
        outst--;
      end else begin
        avm.avm_readdatavalid = 1'b0;
      end

      prev_wr_stall = avm.avm_write && avm.avm_waitrequest;
      prev_rd_stall = avm.avm_read && avm.avm_waitrequest;
      prev_addr     = avm.avm_address;
      prev_wdata    = avm.avm_writedata;
    end
  end

  task automatic pulse_start();
    @(negedge clk); #2 start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
  endtask

  // Accepted start: expect 16 writes then 16 reads in address order
  task automatic run_start();
    @(negedge clk); #2 start = 1'b1;
    for (int i = 0; i <= int'(END_A); i++) begin
      exp_wr.push_back(AW'(i));
      exp_rd.push_back(AW'(i));
    end
    wr_cnt = 0; rd_cnt = 0; max_outst = 0;
    @(negedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check_eq({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_run(input string tag, input logic [15:0] e_err,
                           input logic [AW-1:0] e_first, input logic e_pass);
    check_eq({tag, "_pass"}, 64'(pass), 64'(e_pass));
    check_eq({tag, "_fail"}, 64'(fail), 64'(!e_pass));
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_errcnt"}, 64'(err_count), 64'(e_err));
    check_eq({tag, "_firsterr"}, 64'(first_err_addr), 64'(e_first));
    check_eq({tag, "_nwr"}, 64'(wr_cnt), 64'd16);
    check_eq({tag, "_nrd"}, 64'(rd_cnt), 64'd16);
    check_eq({tag, "_sb_empty"}, 64'(exp_wr.size() + exp_rd.size()), 64'd0);
    check_eq({tag, "_outst_le_max"}, 64'(max_outst <= int'(MO)), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_flags"}, {58'b0, avm.avm_write, avm.avm_read, busy, done, pass, fail}, 64'd0);
    check_eq({tag, "_addr"}, 64'(avm.avm_address), 64'd0);
    check_eq({tag, "_wdata"}, avm.avm_writedata, 64'd0);
    check_eq({tag, "_errcnt"}, 64'(err_count), 64'd0);
    check_eq({tag, "_firsterr"}, 64'(first_err_addr), 64'd0);
  endtask

  initial begin
    int n;
    init_done = 1'b1;
    cal_success = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(negedge clk); #2 reset_n = 1'b1;

    // Ideal zero-wait slave, 2-cycle read latency
    run_start();
    wait_done("ideal", 500);
    check_run("ideal", 16'd0, '0, 1'b1);

    // waitrequest on alternate cycles
    ws_alt = 1'b1;
    run_start();
    wait_done("stall", 1000);
    check_run("stall", 16'd0, '0, 1'b1);
    ws_alt = 1'b0;

    // Bit 0 corrupted at addresses 3 and 9
    corrupt_mask = 16'h0208;
    run_start();
    wait_done("corrupt", 500);
    check_run("corrupt", 16'd2, 24'd3, 1'b0);
    corrupt_mask = '0;

    // Calibration failure while waiting
    cal_success = 1'b0;
    pulse_start();
    wr_cnt = 0; rd_cnt = 0;
    repeat (3) @(negedge clk);
    check_eq("calwait_busy", 64'(busy), 64'd1);
    @(negedge clk); #2 cal_fail = 1'b1;
    @(negedge clk); #2 cal_fail = 1'b0;
    check_eq("calerr_flags", {60'b0, busy, done, pass, fail}, 64'b0101);
    repeat (3) @(negedge clk);
    check_eq("calerr_no_cmd", 64'(wr_cnt + rd_cnt), 64'd0);

    // cal_fail and cal_success in the same cycle: failure wins
    pulse_start();
    repeat (2) @(negedge clk);
    #2 cal_success = 1'b1; cal_fail = 1'b1;
    @(negedge clk); #2 cal_fail = 1'b0;
    check_eq("calboth_flags", {60'b0, busy, done, pass, fail}, 64'b0101);
    repeat (3) @(negedge clk);
    check_eq("calboth_no_cmd", 64'(wr_cnt + rd_cnt), 64'd0);

    // Long read latency, reset in the middle of READ
    lat = 20;
    run_start();
    n = 0;
    while (rd_cnt < 10 && n < 2000) begin @(negedge clk); n++; end
    check_eq("lat20_reads_started", 64'(rd_cnt >= 10), 64'd1);
    check_eq("lat20_outst_max", 64'(max_outst), 64'(MO));
    #2 reset_n = 1'b0;
    #1 check_zero("midreset");
    repeat (3) @(negedge clk);
    exp_wr.delete();
    exp_rd.delete();
    #2 reset_n = 1'b1;
    run_start();
    wait_done("rerun", 3000);
    check_run("rerun", 16'd0, '0, 1'b1);
    lat = 2;

    // start while busy is ignored and does not clear counters
    corrupt_mask = 16'h0208;
    run_start();
    repeat (4) @(negedge clk);
    pulse_start();
    check_eq("busy_start_wr_busy", 64'(busy), 64'd1);
    n = 0;
    while (err_count == 16'd0 && n < 500) begin @(negedge clk); n++; end
    check_eq("busy_start_err_seen", 64'(err_count != 16'd0), 64'd1);
    pulse_start();
    check_eq("busy_start_err_kept", 64'(err_count != 16'd0), 64'd1);
    check_eq("busy_start_first_kept", 64'(first_err_addr), 64'd3);
    wait_done("busy_start", 500);
    check_run("busy_start", 16'd2, 24'd3, 1'b0);
    corrupt_mask = '0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Overall time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr3_mem_tester.md
DDR3_MEM_TESTER -- requirements
Module: ddr3_mem_tester

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter ADDR_W, 24, Avalon word-address width.
REQ-003 Parameter DATA_W, 64, Avalon data width; SHALL be a multiple of 32.
REQ-004 Parameter END_ADDR, 24'hFF_FFFF, last word address tested; the range starts at 0.
REQ-005 Parameter MAX_OUTST, 8, maximum outstanding reads.
REQ-006 clk  in  1  sole clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  single-cycle pulse that begins a test run.
REQ-009 init_done, cal_success, cal_fail  in  1 each  memory controller status.
REQ-010 avm_address  out  ADDR_W  word address.
REQ-011 avm_write, avm_read  out  1 each  commands.
REQ-012 avm_writedata  out  DATA_W; avm_byteenable  out  DATA_W/8, all ones.
REQ-013 avm_waitrequest  in  1; avm_readdata  in  DATA_W; avm_readdatavalid  in  1.
REQ-014 busy, done, pass, fail  out  1 each  run status.
REQ-015 err_count  out  16  mismatch count; first_err_addr  out  ADDR_W  address of the first mismatch.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT_CAL, WRITE, READ, DRAIN, DONE and CAL_ERR.
REQ-017 IDLE/DONE/CAL_ERR + start: clear err_count, first_err_addr, pass, fail and done, then go to WAIT_CAL; start SHALL be ignored in every other state.
REQ-018 WAIT_CAL: init_done&&cal_success -> WRITE with address 0; cal_fail -> CAL_ERR; if both occur in the same cycle, cal_fail SHALL win.
REQ-019 WRITE: avm_write=1 every cycle; address, data and command SHALL be held stable while avm_waitrequest=1; a word is accepted on avm_write&&!avm_waitrequest, which increments the address; acceptance at END_ADDR -> READ with address 0.
REQ-020 READ: avm_read=1 while outstanding<MAX_OUTST; issue counts on avm_read&&!avm_waitrequest; the issue at END_ADDR -> DRAIN.
REQ-021 The outstanding counter SHALL increment on issue and decrement on avm_readdatavalid; simultaneous issue and return SHALL leave it unchanged.
REQ-022 Each avm_readdatavalid in READ/DRAIN SHALL compare against the expected pattern for the compare pointer, then increment the pointer; readdatavalid in other states SHALL be ignored.
REQ-023 On mismatch, err_count SHALL increment, saturating at 16'hFFFF; the first mismatch of a run SHALL latch first_err_addr.
REQ-024 DRAIN: the compare of address END_ADDR -> DONE; pass=(err_count==0), fail=!pass and done=1, all held until the next start.
REQ-025 CAL_ERR: done=1, fail=1, pass=0.
REQ-026 busy SHALL be 1 in WAIT_CAL, WRITE, READ and DRAIN.
REQ-027 Default pattern: even 32-bit lanes = the word address zero-extended to 32 bits; odd lanes = the bitwise inverse of that value.
REQ-028 Latency: the first avm_write SHALL assert in the cycle after WAIT_CAL sees init_done&&cal_success; a readdatavalid SHALL update err_count one cycle after its arrival.

Reset
REQ-029 Assertion of reset_n=0 SHALL immediately force IDLE and zero every output, counter and pointer, including mid-burst; no command SHALL be completed after reset.

Configuration
REQ-030 With DDR3_TEST_LFSR_EN defined, the pattern source SHALL be a 32-bit Galois LFSR (x^32+x^22+x^2+x+1, seed 32'hACE1_0001).
- The write LFSR advances once per accepted write.
- A separate compare LFSR is reseeded on entry to READ and advances once per compare.
- Even lanes = LFSR value; odd lanes = its inverse.
REQ-031 Without DDR3_TEST_LFSR_EN, the block SHALL use the REQ-027 address pattern and SHALL contain no LFSR logic.

Structure
REQ-032 A shared package ddr3_test_pkg SHALL hold the FSM state enum, the LFSR polynomial and seed, and the outstanding-counter width function.
REQ-033 The pattern generator SHALL be one sub-module, ddr3_pattern_gen (inputs: address, advance, reseed; output: DATA_W pattern), instantiated twice, once for write and once for compare.

Verification
REQ-034 The bench SHALL cover these directed scenarios with END_ADDR=15:
- Ideal slave with zero-wait, 2-cycle read latency; start -> 16 writes then 16 reads, done=1, pass=1, err_count=0.
- Slave asserts waitrequest on alternate cycles -> address and data stable while stalled; still 16 writes, 16 reads and pass=1.
- Slave corrupts bit 0 of the words at addresses 3 and 9 -> err_count=2, first_err_addr=3, fail=1.
- cal_fail pulses in WAIT_CAL -> CAL_ERR with done=1, fail=1 and no avm command.
- Read latency of 20 cycles -> outstanding never exceeds 8; reset_n pulsed low during READ -> all outputs 0 next sample and start re-runs to pass.
- start pulsed while busy -> ignored, with no counter reset.
